// File: rtl/buffer_pkg.sv
// Shared constants and pointer helper for the circular request buffer.
// Pure definitions; no state, no latency, no flow control.
package buffer_pkg;

  localparam int RODIZIO_DESLIGADO = 0;
  localparam int RODIZIO_LIGADO    = 1;

  // Wrap by compare-and-subtract so any depth works, not only powers of two.
  function automatic int unsigned prox_ptr(input int unsigned ptr,
                                           input int unsigned passo,
                                           input int unsigned prof);
    int unsigned soma;
    soma = ptr + passo;
    if (soma >= prof) soma = soma - prof;
    return soma;
  endfunction

endpackage

// File: rtl/buffer_circular_mem.sv
// Entry storage: two synchronous write ports, one asynchronous read port.
// Writes land on the rising edge; no backpressure, callers never collide addresses.
module buffer_circular_mem #(
  parameter int W    = 77,
  parameter int PROF = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [W-1:0]  wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [W-1:0]  wd1,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [PROF];

  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/buffer_circular.sv
// Circular queue of pending cluster requests; head visible one cycle after any change.
// Inserts are dropped while bloquear is high, so upstream must hold its request.
module buffer_circular
  import buffer_pkg::*;
#(
  parameter int NUM_CLUSTERS  = 5,
  parameter int TAM_ENDERECO  = 64,
  parameter int TAM_HASH_DOIS = 8,
  parameter int PROFUNDIDADE  = 32,
  parameter int MODO_RODIZIO  = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               entrada_valida,
  input  logic [NUM_CLUSTERS-1:0]            bitmap_novo,
  input  logic [TAM_ENDERECO-1:0]            endereco_novo,
  input  logic [TAM_HASH_DOIS-1:0]           hash_nova,
  input  logic                               atualizar,
  input  logic [NUM_CLUSTERS-1:0]            bitmap_atualizado,
  output logic [NUM_CLUSTERS-1:0]            bitmap_atual,
  output logic [TAM_ENDERECO-1:0]            endereco_atual,
  output logic [TAM_HASH_DOIS-1:0]           hash_atual,
  output logic                               saida_valida,
  output logic                               bloquear,
  output logic [$clog2(PROFUNDIDADE+1)-1:0]  ocupacao
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int OW = $clog2(PROFUNDIDADE+1);
  localparam int W  = TAM_ENDERECO + TAM_HASH_DOIS + NUM_CLUSTERS;

  logic [PW-1:0] cab, cauda, cauda_um, cab_prox, cauda_prox;
  logic [OW-1:0] ocup_prox;
  logic          ins, srv, retira, gira, no_local;
  logic [W-1:0]  cab_dat, upd_dat, novo_dat, wd0, wd1;
  logic          we0, we1;
  logic [PW-1:0] wa0, wa1;

  logic [TAM_ENDERECO-1:0]  cab_end;
  logic [TAM_HASH_DOIS-1:0] cab_hash;
  logic [NUM_CLUSTERS-1:0]  cab_bmp;

  assign {cab_end, cab_hash, cab_bmp} = cab_dat;

  assign saida_valida = (ocupacao != '0);
  assign bloquear     = (ocupacao == OW'(PROFUNDIDADE));

  assign ins      = entrada_valida && !bloquear;
  assign srv      = atualizar && saida_valida;
  assign retira   = srv && (bitmap_atualizado == '0);
  assign gira     = srv && !retira && (MODO_RODIZIO == RODIZIO_LIGADO);
  assign no_local = srv && !retira && !gira;

  assign upd_dat  = {cab_end, cab_hash, bitmap_atualizado};
  assign novo_dat = {endereco_novo, hash_nova, bitmap_novo};
  assign cauda_um = PW'(prox_ptr(32'(cauda), 1, PROFUNDIDADE));

  // Port 0 carries the served entry (in place or rotated), else a plain insert;
  // port 1 takes the new entry whenever port 0 is already busy.
  assign we0 = no_local || gira || ins;
  assign wa0 = no_local ? cab : cauda;
  assign wd0 = (no_local || gira) ? upd_dat : novo_dat;
  assign we1 = ins && (no_local || gira);
  assign wa1 = gira ? cauda_um : cauda;
  assign wd1 = novo_dat;

  buffer_circular_mem #(
    .W    (W),
    .PROF (PROFUNDIDADE),
    .AW   (PW)
  ) u_mem (
    .clk (clk),
    .we0 (we0),
    .wa0 (wa0),
    .wd0 (wd0),
    .we1 (we1),
    .wa1 (wa1),
    .wd1 (wd1),
    .ra  (cab),
    .rd  (cab_dat)
  );

  always_comb begin
    cab_prox   = cab;
    cauda_prox = cauda;
    ocup_prox  = ocupacao;
    if (retira || gira) cab_prox = PW'(prox_ptr(32'(cab), 1, PROFUNDIDADE));
    if (ins && gira)         cauda_prox = PW'(prox_ptr(32'(cauda), 2, PROFUNDIDADE));
    else if (ins || gira)    cauda_prox = cauda_um;
    if (ins && !retira)      ocup_prox = ocupacao + OW'(1);
    else if (!ins && retira) ocup_prox = ocupacao - OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cab      <= '0;
      cauda    <= '0;
      ocupacao <= '0;
    end else begin
      cab      <= cab_prox;
      cauda    <= cauda_prox;
      ocupacao <= ocup_prox;
    end
  end

  assign bitmap_atual   = saida_valida ? cab_bmp  : '0;
  assign endereco_atual = saida_valida ? cab_end  : '0;
  assign hash_atual     = saida_valida ? cab_hash : '0;

endmodule
